// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_GRANT   = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int DMA_NUM_CH = 4;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : dma_prio_enc
// Description : Combinational priority encoder whose search starts at base;
//               base = 0 gives fixed priority (channel 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
module dma_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   base,
    output logic              any,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        w_cand = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_cand = CH_W'((int'(base) + i) % NUM_CH);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule : dma_prio_enc
`default_nettype wire

// File: rtl/dma_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_request_arbiter
// Description : DREQ arbitration and HRQ/HLDA bus-hold sequencer for an
//               8237A-style DMA controller. Rotating priority is built only
//               when ROTATE_PRIORITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_request_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] dreq,
    input  logic [NUM_CH-1:0] mask,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              cfgRotate,
    input  logic              hlda,
    input  logic              xferDone,
    input  logic              eopIn,
    output logic              validDREQ,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic              validDACK,
    output logic [CH_W-1:0]   activeCh,
    output logic              busLost
);

    arb_state_t        state_q;
    logic [NUM_CH-1:0] dreq_q;
    logic              valid_dreq_q;
    logic              hrq_q;
    logic              valid_dack_q;
    logic [CH_W-1:0]   active_ch_q;
    logic              bus_lost_q;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_dack_raw;
    logic [CH_W-1:0]   w_base;
    logic              w_any;
    logic [CH_W-1:0]   w_idx;
    logic              w_done;

    assign w_req  = (dreq_q ^ {NUM_CH{dreqSenseLow}}) & ~mask;
    assign w_done = xferDone | eopIn;

`ifdef ROTATE_PRIORITY_EN
    logic [CH_W-1:0] base_q;
    logic [CH_W-1:0] base_d;

    assign base_d = (active_ch_q == CH_W'(NUM_CH - 1)) ? '0 : active_ch_q + CH_W'(1);

    // Only a completed service advances the rotation; a lost bus does not.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_q <= '0;
        end else if (state_q == ARB_GRANT && w_done) begin
            base_q <= base_d;
        end
    end

    assign w_base = cfgRotate ? base_q : '0;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = cfgRotate;
    assign w_base       = '0;
`endif

    dma_prio_enc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_prio_enc (
        .req  (w_req),
        .base (w_base),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ARB_IDLE;
            dreq_q       <= '0;
            valid_dreq_q <= 1'b0;
            hrq_q        <= 1'b0;
            valid_dack_q <= 1'b0;
            active_ch_q  <= '0;
            bus_lost_q   <= 1'b0;
        end else begin
            dreq_q       <= dreq;
            valid_dreq_q <= w_any;
            bus_lost_q   <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (w_any) begin
                        active_ch_q <= w_idx;
                        hrq_q       <= 1'b1;
                        state_q     <= ARB_REQ;
                    end else begin
                        hrq_q <= 1'b0;
                    end
                end
                ARB_REQ: begin
                    // The latched channel is kept; late higher-priority requests wait.
                    if (hlda) begin
                        valid_dack_q <= 1'b1;
                        state_q      <= ARB_GRANT;
                    end else if (!w_req[active_ch_q]) begin
                        hrq_q   <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    if (w_done) begin
                        valid_dack_q <= 1'b0;
                        hrq_q        <= 1'b0;
                        state_q      <= ARB_RELEASE;
                    end else if (!hlda) begin
                        valid_dack_q <= 1'b0;
                        hrq_q        <= 1'b0;
                        bus_lost_q   <= 1'b1;
                        state_q      <= ARB_IDLE;
                    end
                end
                ARB_RELEASE: begin
                    if (!hlda) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Polarity is applied after the register so a command write flips dack at once.
    assign w_dack_raw = valid_dack_q ? (NUM_CH'(1) << active_ch_q) : '0;
    assign dack       = w_dack_raw ^ {NUM_CH{~dackSenseHigh}};

    assign validDREQ = valid_dreq_q;
    assign hrq       = hrq_q;
    assign validDACK = valid_dack_q;
    assign activeCh  = active_ch_q;
    assign busLost   = bus_lost_q;

endmodule : dma_request_arbiter
`default_nettype wire

// File: tb/tb_dma_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_request_arbiter
// Description : Directed self-checking bench for dma_request_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_request_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
`ifdef ROTATE_PRIORITY_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic              CLK;
    logic              RESET;
    logic [NUM_CH-1:0] dreq;
    logic [NUM_CH-1:0] mask;
    logic              dreqSenseLow;
    logic              dackSenseHigh;
    logic              cfgRotate;
    logic              hlda;
    logic              xferDone;
    logic              eopIn;
    logic              validDREQ;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic              validDACK;
    logic [CH_W-1:0]   activeCh;
    logic              busLost;

    int checks = 0;
    int errors = 0;

    dma_request_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .dreq          (dreq),
        .mask          (mask),
        .dreqSenseLow  (dreqSenseLow),
        .dackSenseHigh (dackSenseHigh),
        .cfgRotate     (cfgRotate),
        .hlda          (hlda),
        .xferDone      (xferDone),
        .eopIn         (eopIn),
        .validDREQ     (validDREQ),
        .hrq           (hrq),
        .dack          (dack),
        .validDACK     (validDACK),
        .activeCh      (activeCh),
        .busLost       (busLost)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hrq(input string tag);
        for (int i = 0; i < 10 && hrq !== 1'b1; i++) tick();
        chk(tag, 32'(hrq), 32'd1);
    endtask

    initial begin
        RESET = 1'b1; dreq = 4'b1111; mask = 4'b0000;
        dreqSenseLow = 1'b0; dackSenseHigh = 1'b1; cfgRotate = 1'b0;
        hlda = 1'b0; xferDone = 1'b0; eopIn = 1'b0;
        tick(); tick(); tick();

        // Test 1: reset values and 2-cycle request latency
        chk("rst_hrq",       32'(hrq),       32'd0);
        chk("rst_dack",      32'(dack),      32'h0);
        chk("rst_validDACK", 32'(validDACK), 32'd0);
        chk("rst_validDREQ", 32'(validDREQ), 32'd0);
        chk("rst_busLost",   32'(busLost),   32'd0);
        chk("rst_activeCh",  32'(activeCh),  32'd0);
        RESET = 1'b0;
        tick();
        chk("lat_hrq_c1", 32'(hrq), 32'd0);
        tick();
        chk("lat_hrq_c2",       32'(hrq),       32'd1);
        chk("lat_validDREQ_c2", 32'(validDREQ), 32'd1);
        chk("lat_activeCh",     32'(activeCh),  32'd0);
        hlda = 1'b1;
        tick();
        chk("t1_dack", 32'(dack), 32'h1);
        xferDone = 1'b1;
        tick();
        xferDone = 1'b0; hlda = 1'b0; dreq = 4'b0000;
        tick(); tick(); tick();

        // Test 2: fixed priority picks channel 1, grant survives mask/polarity writes
        dreq = 4'b0110;
        tick(); tick();
        chk("t2_hrq",      32'(hrq),      32'd1);
        chk("t2_activeCh", 32'(activeCh), 32'd1);
        chk("t2_dack_pre", 32'(dack),     32'h0);
        hlda = 1'b1;
        tick();
        chk("t2_dack",      32'(dack),      32'h2);
        chk("t2_validDACK", 32'(validDACK), 32'd1);
        mask = 4'b0010;
        tick();
        chk("t2_mask_keep", 32'(dack), 32'h2);
        dackSenseHigh = 1'b0;
        #1;
        chk("t2_pol_flip", 32'(dack), 32'hD);
        dackSenseHigh = 1'b1; mask = 4'b0000;
        xferDone = 1'b1;
        tick();
        xferDone = 1'b0;
        chk("t2_done_dack",      32'(dack),      32'h0);
        chk("t2_done_hrq",       32'(hrq),       32'd0);
        chk("t2_done_validDACK", 32'(validDACK), 32'd0);
        tick();
        chk("t2_release_hold", 32'(hrq), 32'd0);
        hlda = 1'b0; dreq = 4'b0000;
        tick(); tick(); tick();

        // Test 3: four back-to-back grants with cfgRotate=1 from a fresh base
        RESET = 1'b1; dreq = 4'b1111; cfgRotate = 1'b1;
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_hrq($sformatf("t3_hrq_%0d", k));
            chk($sformatf("t3_activeCh_%0d", k), 32'(activeCh), ROT ? 32'(k) : 32'd0);
            hlda = 1'b1;
            tick();
            xferDone = 1'b1;
            tick();
            xferDone = 1'b0; hlda = 1'b0;
            tick();
        end
        dreq = 4'b0000;
        tick(); tick(); tick();

        // Test 4: request withdrawn before hlda
        dreq = 4'b0100;
        wait_hrq("t4_hrq");
        chk("t4_activeCh", 32'(activeCh), 32'd2);
        dreq = 4'b0000;
        tick();
        chk("t4_hrq_held", 32'(hrq), 32'd1);
        tick();
        chk("t4_hrq_drop",   32'(hrq),       32'd0);
        chk("t4_dack",       32'(dack),      32'h0);
        chk("t4_validDACK",  32'(validDACK), 32'd0);
        chk("t4_validDREQ",  32'(validDREQ), 32'd0);
        tick();
        chk("t4_idle_hrq", 32'(hrq), 32'd0);

        // Test 5: hlda lost during GRANT; base must not advance
        dreq = 4'b0010;
        wait_hrq("t5_hrq");
        chk("t5_activeCh", 32'(activeCh), 32'd1);
        hlda = 1'b1;
        tick();
        chk("t5_dack", 32'(dack), 32'h2);
        hlda = 1'b0; dreq = 4'b1111;
        tick();
        chk("t5_busLost",   32'(busLost),   32'd1);
        chk("t5_dack_drop", 32'(dack),      32'h0);
        chk("t5_hrq_drop",  32'(hrq),       32'd0);
        tick();
        chk("t5_busLost_pulse", 32'(busLost),  32'd0);
        chk("t5_rearb_hrq",     32'(hrq),      32'd1);
        chk("t5_base_kept",     32'(activeCh), 32'd0);
        dreq = 4'b0000;
        tick(); tick(); tick();
        chk("t5_clean_hrq", 32'(hrq), 32'd0);

        // Test 6: inverted DREQ/DACK polarity with mask, ended by EOP
        cfgRotate = 1'b0; dreqSenseLow = 1'b1; dackSenseHigh = 1'b0;
        mask = 4'b0001; dreq = 4'b1100;
        #1;
        chk("t6_dack_idle", 32'(dack), 32'hF);
        wait_hrq("t6_hrq");
        chk("t6_activeCh", 32'(activeCh), 32'd1);
        hlda = 1'b1;
        tick();
        chk("t6_dack", 32'(dack), 32'hD);
        eopIn = 1'b1;
        tick();
        eopIn = 1'b0;
        chk("t6_eop_dack", 32'(dack), 32'hF);
        chk("t6_eop_hrq",  32'(hrq),  32'd0);
        hlda = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dma_request_arbiter
`default_nettype wire
